// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with a fixed access latency.
// Stalls the pipeline while a legal request is in flight and pulses err_o on illegal requests.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_op_wr;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_data;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic w_req;
    logic w_illegal;
    logic w_legal;
    logic w_mem_we;

    assign w_req     = MemRead_i | MemWrite_i;
    assign w_illegal = (MemRead_i & MemWrite_i)
                     | (addr_i[1:0] != 2'b00)
                     | ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
    assign w_legal   = w_req & ~w_illegal;

    // Stall covers the accepting IDLE cycle plus every BUSY cycle; reset always releases it.
    assign stall_o = ~rst_i & (((r_state == S_IDLE) & w_legal) | (r_state == S_BUSY));

    assign data_o  = r_data;
    assign ready_o = r_ready;
    assign err_o   = r_err;

    assign w_mem_we = ~rst_i & (r_state == S_BUSY) & (r_cnt == 4'd0) & r_op_wr;

    // The array has no reset so its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_legal) begin
                        r_op_wr <= MemWrite_i;
                        r_idx   <= addr_i[AW+1:2];
                        r_wdata <= data_i;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        if (!r_op_wr) begin
                            r_data <= r_mem[r_idx];
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked every cycle against a
// cycle-offset transaction model, plus literal expectations on selected accesses.
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic clk;
    logic [1:0]       rst_r;
    logic [1:0]       rd_r;
    logic [1:0]       wr_r;
    logic [1:0][31:0] addr_r;
    logic [1:0][31:0] wdata_r;
    logic [1:0][31:0] dout_w;
    logic [1:0]       ready_w;
    logic [1:0]       stall_w;
    logic [1:0]       err_w;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i      (clk),
        .rst_i      (rst_r[0]),
        .MemRead_i  (rd_r[0]),
        .MemWrite_i (wr_r[0]),
        .addr_i     (addr_r[0]),
        .data_i     (wdata_r[0]),
        .data_o     (dout_w[0]),
        .ready_o    (ready_w[0]),
        .stall_o    (stall_w[0]),
        .err_o      (err_w[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst_r[1]),
        .MemRead_i  (rd_r[1]),
        .MemWrite_i (wr_r[1]),
        .addr_i     (addr_r[1]),
        .data_i     (wdata_r[1]),
        .data_o     (dout_w[1]),
        .ready_o    (ready_w[1]),
        .stall_o    (stall_w[1]),
        .err_o      (err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t: got %08h required %08h", name, k, $time, got, exp);
        end
    endtask

    // Transaction model: an access accepted in cycle T stalls T..T+LAT and completes in T+LAT+1.
    logic        m_busy [2];
    int          m_tacc [2];
    logic        m_wr   [2];
    logic [4:0]  m_idx  [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_data [2];
    logic        m_err  [2];
    logic [31:0] m_mem  [2][DEPTH];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_tacc[k] = 0;
            m_wr[k]   = 1'b0;
            m_idx[k]  = '0;
            m_wd[k]   = '0;
            m_data[k] = '0;
            m_err[k]  = 1'b0;
        end
    end

    always @(negedge clk) begin
        int   lat;
        int   ph;
        logic ex_rdy;
        logic ex_stall;
        logic nerr;
        logic req;
        logic ill;
        for (int k = 0; k < 2; k++) begin
            lat    = (k == 0) ? LAT0 : LAT1;
            ph     = cyc - m_tacc[k];
            ex_rdy = m_busy[k] && (ph == lat + 1);
            if (ex_rdy) begin
                if (m_wr[k]) m_mem[k][m_idx[k]] = m_wd[k];
                else         m_data[k] = m_mem[k][m_idx[k]];
            end
            nerr = 1'b0;
            if (!m_busy[k]) begin
                req = rd_r[k] | wr_r[k];
                ill = (rd_r[k] & wr_r[k]) | (addr_r[k][1:0] != 2'b00) | (addr_r[k][31:2] >= 30'(DEPTH));
                if (!rst_r[k] && req && !ill) begin
                    m_busy[k] = 1'b1;
                    m_tacc[k] = cyc;
                    m_wr[k]   = wr_r[k];
                    m_idx[k]  = addr_r[k][6:2];
                    m_wd[k]   = wdata_r[k];
                end
                nerr = !rst_r[k] && req && ill;
            end
            ph       = cyc - m_tacc[k];
            ex_stall = !rst_r[k] && m_busy[k] && (ph <= lat);
            if (chk_en) begin
                check("model_stall", k, {31'd0, stall_w[k]}, {31'd0, ex_stall});
                check("model_ready", k, {31'd0, ready_w[k]}, {31'd0, ex_rdy});
                check("model_err",   k, {31'd0, err_w[k]},   {31'd0, m_err[k]});
                check("model_data",  k, dout_w[k], m_data[k]);
            end
            m_err[k] = nerr;
            if (ex_rdy) m_busy[k] = 1'b0;
            if (rst_r[k]) begin
                m_busy[k] = 1'b0;
                m_data[k] = '0;
                m_err[k]  = 1'b0;
            end
        end
    end

    // Starts just after a rising edge; holds the request for `hold` cycles, observes `obs` cycles.
    task automatic do_req(input int k, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input int obs,
                          output logic [7:0] st, output logic [7:0] rdy, output logic [7:0] er,
                          output logic [31:0] dl);
        st = '0; rdy = '0; er = '0; dl = '0;
        rd_r[k] = rd; wr_r[k] = wr; addr_r[k] = a; wdata_r[k] = d;
        for (int i = 0; i < obs; i++) begin
            if (i == hold) begin
                rd_r[k] = 1'b0; wr_r[k] = 1'b0;
            end
            @(negedge clk);
            st[i]  = stall_w[k];
            rdy[i] = ready_w[k];
            er[i]  = err_w[k];
            dl     = dout_w[k];
            @(posedge clk); #1;
        end
        rd_r[k] = 1'b0; wr_r[k] = 1'b0;
    endtask

    task automatic legal(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input string name, input logic chk_data, input logic [31:0] exp_d);
        logic [7:0]  st, rdy, er;
        logic [31:0] dl;
        int lat;
        lat = (k == 0) ? LAT0 : LAT1;
        do_req(k, ~wr, wr, a, d, lat + 2, lat + 2, st, rdy, er, dl);
        check({name, "_stall"}, k, {24'd0, st},  (k == 0) ? 32'h07 : 32'h03);
        check({name, "_ready"}, k, {24'd0, rdy}, (k == 0) ? 32'h08 : 32'h04);
        if (chk_data) check({name, "_data"}, k, dl, exp_d);
    endtask

    task automatic illegal(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input string name, input logic [31:0] held);
        logic [7:0]  st, rdy, er;
        logic [31:0] dl;
        do_req(0, rd, wr, a, d, 1, 3, st, rdy, er, dl);
        check({name, "_stall"}, 0, {24'd0, st},  32'h0);
        check({name, "_ready"}, 0, {24'd0, rdy}, 32'h0);
        check({name, "_err"},   0, {24'd0, er},  32'h2);
        check({name, "_data"},  0, dl, held);
    endtask

    initial begin
        logic [7:0]  st, rdy, er;
        logic [31:0] dl;
        rst_r = 2'b11; rd_r = '0; wr_r = '0; addr_r = '0; wdata_r = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_r  = 2'b00;
        chk_en = 1'b1;

        do_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5, st, rdy, er, dl);
        check("idle_stall", 0, {24'd0, st},  32'h0);
        check("idle_ready", 0, {24'd0, rdy}, 32'h0);
        check("idle_err",   0, {24'd0, er},  32'h0);
        check("idle_data",  0, dl, 32'h0);

        legal(0, 1'b1, 32'h8, 32'hDEADBEEF, "wr8", 1'b0, 32'h0);
        legal(0, 1'b1, 32'h4, 32'h0BADF00D, "wr4", 1'b0, 32'h0);
        legal(0, 1'b0, 32'h8, 32'h0, "rd8", 1'b1, 32'hDEADBEEF);

        illegal(1'b1, 1'b0, 32'h6,  32'h0,         "mis_rd",  32'hDEADBEEF);
        illegal(1'b0, 1'b1, 32'h6,  32'hFFFFFFFF, "mis_wr",  32'hDEADBEEF);
        illegal(1'b1, 1'b0, 32'h80, 32'h0,         "oor_rd",  32'hDEADBEEF);
        illegal(1'b0, 1'b1, 32'h80, 32'h77777777, "oor_wr",  32'hDEADBEEF);
        illegal(1'b1, 1'b1, 32'h8,  32'h11111111, "both",    32'hDEADBEEF);

        legal(0, 1'b0, 32'h4, 32'h0, "rb4", 1'b1, 32'h0BADF00D);
        legal(0, 1'b0, 32'h8, 32'h0, "rb8", 1'b1, 32'hDEADBEEF);

        legal(0, 1'b1, 32'h10, 32'hA5A5A5A5, "wr10", 1'b0, 32'h0);
        legal(0, 1'b0, 32'h10, 32'h0, "rd10a", 1'b1, 32'hA5A5A5A5);
        wr_r[0] = 1'b1; addr_r[0] = 32'h10; wdata_r[0] = 32'h12345678;
        @(posedge clk); #1;
        rst_r[0] = 1'b1; wr_r[0] = 1'b0;
        @(posedge clk); #1;
        rst_r[0] = 1'b0;
        @(negedge clk);
        check("rst_stall", 0, {31'd0, stall_w[0]}, 32'h0);
        check("rst_ready", 0, {31'd0, ready_w[0]}, 32'h0);
        check("rst_data",  0, dout_w[0], 32'h0);
        @(posedge clk); #1;
        legal(0, 1'b0, 32'h10, 32'h0, "rd10b", 1'b1, 32'hA5A5A5A5);

        legal(0, 1'b1, 32'h14, 32'h14141414, "wr14", 1'b0, 32'h0);
        wr_r[0] = 1'b1; addr_r[0] = 32'hC; wdata_r[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        addr_r[0] = 32'h14; wdata_r[0] = 32'h55555555;
        repeat (3) begin
            @(posedge clk); #1;
        end
        wr_r[0] = 1'b0;
        legal(0, 1'b0, 32'hC,  32'h0, "rdC",  1'b1, 32'hCAFEF00D);
        legal(0, 1'b0, 32'h14, 32'h0, "rd14", 1'b1, 32'h14141414);

        legal(1, 1'b1, 32'h0, 32'h11112222, "l1_wr0", 1'b0, 32'h0);
        legal(1, 1'b1, 32'h4, 32'h33334444, "l1_wr4", 1'b0, 32'h0);
        legal(1, 1'b0, 32'h0, 32'h0, "l1_rd0", 1'b1, 32'h11112222);
        legal(1, 1'b0, 32'h4, 32'h0, "l1_rd4", 1'b1, 32'h33334444);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
